ysyx_25040109_trap_unit: RTL and testbench
==========================================

YSYX_25040109_TRAP_UNIT -- requirements
Module: ysyx_25040109_trap_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named as below.
REQ-002 Parameter: DATA_WIDTH, default 32, width of CSR data and PC.
REQ-003 Ports SHALL be exactly:
- clock  in  1  sole clock, all state updates on posedge.
- reset  in  1  synchronous, active-high.
- trap_valid  in  1  core requests trap entry or return.
- trap_ready  out  1  unit can accept a request.
- trap_type  in  2  00 ecall, 01 ebreak, 10 mret, 11 reserved.
- trap_pc  in  DATA_WIDTH  PC of the trapping instruction.
- csr_we  out  1  CSR write strobe to the register file.
- csr_addr  out  12  CSR address for the write or read.
- csr_wdata  out  DATA_WIDTH  CSR write data.
- csr_rdata  in  DATA_WIDTH  combinational read data for csr_addr.
- mepc_in  in  DATA_WIDTH  current mepc.
- mtvec_in  in  DATA_WIDTH  current mtvec.
- csr_own  out  1  unit owns the CSR port; core muxes its own CSR writes off.
- redirect_valid  out  1  one-cycle PC redirect pulse.
- redirect_pc  out  DATA_WIDTH  redirect target, valid only with redirect_valid.

Function
REQ-004 The FSM states SHALL be IDLE, WR_MEPC, WR_MCAUSE, WR_MSTATUS and REDIRECT.
REQ-005 trap_ready SHALL be 1 only in IDLE.
REQ-006 A request SHALL be accepted on a posedge with trap_valid=1, trap_ready=1 and trap_type!=11; trap_type and trap_pc are latched at that edge.
REQ-007 A reserved type (11) SHALL be ignored: no state change, no CSR write, no redirect.
REQ-008 ecall/ebreak SHALL sequence IDLE->WR_MEPC->WR_MCAUSE->WR_MSTATUS->REDIRECT->IDLE, one cycle per state.
REQ-009 mret SHALL sequence IDLE->WR_MSTATUS->REDIRECT->IDLE.
REQ-010 In WR_MEPC: csr_we=1, csr_addr=0x341, csr_wdata=latched pc.
REQ-011 In WR_MCAUSE: csr_we=1, csr_addr=0x342, csr_wdata=11 for ecall, 3 for ebreak.
REQ-012 In WR_MSTATUS: csr_addr=0x300 and csr_we=1; csr_wdata is a read-modify-write of csr_rdata in the same cycle.
- Entry (ecall/ebreak): bit7(MPIE)<=bit3(MIE), bit3<=0, bits12:11(MPP)<=11.
- mret: bit3<=bit7, bit7<=1, bits12:11<=11.
- All other bits pass through unchanged.
REQ-013 In REDIRECT: redirect_valid=1, csr_we=0; redirect_pc=mtvec_in for entry, mepc_in for mret, both sampled in that cycle.
REQ-014 Latency: request accepted at edge N gives redirect_valid in cycle N+4 for entry and N+2 for mret, and trap_ready=1 again in cycle N+5 or N+3 respectively.
REQ-015 csr_own SHALL be 1 in every state except IDLE.
REQ-016 In IDLE, csr_we=0, csr_addr=0, csr_wdata=0, redirect_valid=0 and redirect_pc=0.
REQ-017 trap_valid asserted while not ready SHALL be ignored and never queued; the core holds the request.
REQ-018 Exactly one redirect_valid pulse SHALL be produced per accepted request.

Reset
REQ-019 reset=1 at a posedge SHALL force IDLE, clear the latched type and pc, and drive trap_ready=1 with every other output 0 from the next cycle.
REQ-020 Reset mid-sequence SHALL abort with no further CSR write and no redirect; writes already committed are not undone.
REQ-021 reset SHALL take priority over a simultaneous trap_valid; that request is not accepted.

Verification
REQ-022 ecall, pc=0x80000010, mstatus=0x1808, mtvec=0x80000100 -> writes mepc=0x80000010, then mcause=11, then mstatus=0x1880; redirect_pc=0x80000100 at N+4.
REQ-023 ebreak, pc=0x80000020 -> mcause=3; redirect to mtvec at N+4; trap_ready low for exactly 4 cycles.
REQ-024 mret, mstatus=0x1880, mepc=0x80000014 -> mstatus write 0x1888; redirect_pc=0x80000014 at N+2.
REQ-025 trap_type=11 held with trap_valid=1 for 3 cycles -> trap_ready stays 1, no csr_we, no redirect.
REQ-026 reset asserted in WR_MCAUSE -> mepc already written, no mcause/mstatus write, no redirect, IDLE next cycle.
REQ-027 Back-to-back: second ecall held valid during busy -> accepted in the first IDLE cycle after REDIRECT, two distinct redirect pulses.

Source files
------------

// File: rtl/ysyx_25040109_trap_unit.sv
// Trap entry/return sequencer: writes mepc/mcause/mstatus through a shared CSR
// port, then issues a single-cycle PC redirect to mtvec (entry) or mepc (mret).
module ysyx_25040109_trap_unit #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  trap_valid,
    output logic                  trap_ready,
    input  logic [1:0]            trap_type,
    input  logic [DATA_WIDTH-1:0] trap_pc,
    output logic                  csr_we,
    output logic [11:0]           csr_addr,
    output logic [DATA_WIDTH-1:0] csr_wdata,
    input  logic [DATA_WIDTH-1:0] csr_rdata,
    input  logic [DATA_WIDTH-1:0] mepc_in,
    input  logic [DATA_WIDTH-1:0] mtvec_in,
    output logic                  csr_own,
    output logic                  redirect_valid,
    output logic [DATA_WIDTH-1:0] redirect_pc
);

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam logic [1:0] T_ECALL = 2'b00;
    localparam logic [1:0] T_MRET  = 2'b10;
    localparam logic [1:0] T_RSVD  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WR_MEPC,
        WR_MCAUSE,
        WR_MSTATUS,
        REDIRECT
    } state_e;

    state_e                state_q, state_d;
    logic [1:0]            type_q, type_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] mstatus_new;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            type_q  <= 2'b00;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        type_d         = type_q;
        pc_d           = pc_q;
        trap_ready     = 1'b0;
        csr_own        = 1'b1;
        csr_we         = 1'b0;
        csr_addr       = 12'h000;
        csr_wdata      = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        mstatus_new    = csr_rdata;

        case (state_q)
            IDLE: begin
                trap_ready = 1'b1;
                csr_own    = 1'b0;
                if (trap_valid && (trap_type != T_RSVD)) begin
                    type_d  = trap_type;
                    pc_d    = trap_pc;
                    state_d = (trap_type == T_MRET) ? WR_MSTATUS : WR_MEPC;
                end
            end
            WR_MEPC: begin
                csr_we    = 1'b1;
                csr_addr  = CSR_MEPC;
                csr_wdata = pc_q;
                state_d   = WR_MCAUSE;
            end
            WR_MCAUSE: begin
                csr_we    = 1'b1;
                csr_addr  = CSR_MCAUSE;
                csr_wdata = (type_q == T_ECALL) ? DATA_WIDTH'(11) : DATA_WIDTH'(3);
                state_d   = WR_MSTATUS;
            end
            WR_MSTATUS: begin
                // MIE is bit 3, MPIE bit 7, MPP bits 12:11; everything else passes through
                if (type_q == T_MRET) begin
                    mstatus_new[3] = csr_rdata[7];
                    mstatus_new[7] = 1'b1;
                end else begin
                    mstatus_new[7] = csr_rdata[3];
                    mstatus_new[3] = 1'b0;
                end
                mstatus_new[12:11] = 2'b11;
                csr_we    = 1'b1;
                csr_addr  = CSR_MSTATUS;
                csr_wdata = mstatus_new;
                state_d   = REDIRECT;
            end
            REDIRECT: begin
                redirect_valid = 1'b1;
                redirect_pc    = (type_q == T_MRET) ? mepc_in : mtvec_in;
                state_d        = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // An abort in progress must not commit the write or redirect of the current cycle
        if (reset) begin
            csr_we         = 1'b0;
            redirect_valid = 1'b0;
            redirect_pc    = '0;
        end
    end

endmodule

// File: tb/tb_ysyx_25040109_trap_unit.sv
// Bench for the trap sequencer: vector table of trap requests, scoreboard of
// expected CSR writes / redirects, plus reserved, reset-abort and back-to-back cases.
module tb_ysyx_25040109_trap_unit;

    localparam int unsigned DW = 32;

    logic          clock = 1'b0;
    logic          reset;
    logic          trap_valid;
    logic          trap_ready;
    logic [1:0]    trap_type;
    logic [DW-1:0] trap_pc;
    logic          csr_we;
    logic [11:0]   csr_addr;
    logic [DW-1:0] csr_wdata;
    logic [DW-1:0] csr_rdata;
    logic [DW-1:0] mepc_in;
    logic [DW-1:0] mtvec_in;
    logic          csr_own;
    logic          redirect_valid;
    logic [DW-1:0] redirect_pc;

    ysyx_25040109_trap_unit #(.DATA_WIDTH(DW)) dut (
        .clock         (clock),
        .reset         (reset),
        .trap_valid    (trap_valid),
        .trap_ready    (trap_ready),
        .trap_type     (trap_type),
        .trap_pc       (trap_pc),
        .csr_we        (csr_we),
        .csr_addr      (csr_addr),
        .csr_wdata     (csr_wdata),
        .csr_rdata     (csr_rdata),
        .mepc_in       (mepc_in),
        .mtvec_in      (mtvec_in),
        .csr_own       (csr_own),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic        redir;
        logic [11:0] addr;
        logic [31:0] data;
        int          at;
    } exp_t;

    typedef struct {
        logic [1:0]  ttype;
        logic [31:0] pc;
        logic [31:0] mstatus;
        logic [31:0] mtvec;
        logic [31:0] mepc;
        logic [31:0] exp_mcause;
        logic [31:0] exp_mstatus;
        logic [31:0] exp_redir;
        int          busy;
    } vec_t;

    exp_t exp_q[$];
    int   n_cmp   = 0;
    int   n_bad   = 0;
    int   n_redir = 0;
    logic mon_en  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic redir, input logic [11:0] addr, input logic [31:0] data, input int at);
        exp_t e;
        e.redir = redir;
        e.addr  = addr;
        e.data  = data;
        e.at    = at;
        exp_q.push_back(e);
    endtask

    task automatic push_entry(input int c, input logic [31:0] pc, input logic [31:0] cause,
                              input logic [31:0] ms, input logic [31:0] tgt);
        push(1'b0, 12'h341, pc, c + 1);
        push(1'b0, 12'h342, cause, c + 2);
        push(1'b0, 12'h300, ms, c + 3);
        push(1'b1, 12'h000, tgt, c + 4);
    endtask

    // Scoreboard and per-cycle idle/ownership checks
    always @(negedge clock) begin
        if (mon_en) begin
            if (csr_we || redirect_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_event: we=%b addr=%h wdata=%h redir=%b pc=%h cycle %0d",
                             csr_we, csr_addr, csr_wdata, redirect_valid, redirect_pc, cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    n_cmp++;
                    if (csr_we !== !e.redir || redirect_valid !== e.redir ||
                        (e.redir ? redirect_pc : csr_wdata) !== e.data ||
                        (!e.redir && csr_addr !== e.addr) || cyc != e.at) begin
                        n_bad++;
                        $display("FAIL event: got we=%b redir=%b addr=%h data=%h cyc=%0d required redir=%b addr=%h data=%h cyc=%0d",
                                 csr_we, redirect_valid, csr_addr,
                                 redirect_valid ? redirect_pc : csr_wdata, cyc,
                                 e.redir, e.addr, e.data, e.at);
                    end
                end
            end
            if (redirect_valid) n_redir++;
            n_cmp++;
            if (csr_own !== !trap_ready) begin
                n_bad++;
                $display("FAIL own_vs_ready: csr_own=%b trap_ready=%b cycle %0d", csr_own, trap_ready, cyc);
            end
            if (trap_ready === 1'b1) begin
                n_cmp++;
                if ({csr_we, csr_addr, csr_wdata, redirect_valid, redirect_pc} !== '0) begin
                    n_bad++;
                    $display("FAIL idle_outputs: we=%b addr=%h wdata=%h redir=%b pc=%h required all zero",
                             csr_we, csr_addr, csr_wdata, redirect_valid, redirect_pc);
                end
            end
        end
    end

    vec_t vt[6];

    task automatic wait_ready(output int busy);
        busy = 0;
        while (trap_ready !== 1'b1 && busy < 20) begin
            busy++;
            @(posedge clock); #1;
        end
    endtask

    initial begin
        int c;
        int busy;
        int redir_base;

        vt[0] = '{2'b00, 32'h8000_0010, 32'h0000_1808, 32'h8000_0100, 32'h0,
                  32'd11, 32'h0000_1880, 32'h8000_0100, 4};
        vt[1] = '{2'b01, 32'h8000_0020, 32'h0000_0000, 32'h8000_0200, 32'h0,
                  32'd3,  32'h0000_1800, 32'h8000_0200, 4};
        vt[2] = '{2'b10, 32'h0,         32'h0000_1880, 32'h0,         32'h8000_0014,
                  32'd0,  32'h0000_1888, 32'h8000_0014, 2};
        vt[3] = '{2'b10, 32'h0,         32'h0000_0008, 32'h0,         32'h1234_5678,
                  32'd0,  32'h0000_1880, 32'h1234_5678, 2};
        vt[4] = '{2'b00, 32'h8000_0abc, 32'hffff_e777, 32'h8000_0300, 32'h0,
                  32'd11, 32'hffff_ff77, 32'h8000_0300, 4};
        vt[5] = '{2'b01, 32'h0000_0044, 32'h0000_0088, 32'h0000_0400, 32'h0,
                  32'd3,  32'h0000_1880, 32'h0000_0400, 4};

        reset      = 1'b1;
        trap_valid = 1'b0;
        trap_type  = 2'b00;
        trap_pc    = '0;
        csr_rdata  = '0;
        mepc_in    = '0;
        mtvec_in   = '0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        check("rst_ready", trap_ready, 1);
        check("rst_own", csr_own, 0);
        check("rst_we", csr_we, 0);
        check("rst_addr_wdata", {csr_addr, csr_wdata}, 0);
        check("rst_redirect", {redirect_valid, redirect_pc}, 0);
        mon_en = 1'b1;

        for (int i = 0; i < 6; i++) begin
            @(posedge clock); #1;
            c          = cyc;
            trap_valid = 1'b1;
            trap_type  = vt[i].ttype;
            trap_pc    = vt[i].pc;
            csr_rdata  = vt[i].mstatus;
            mtvec_in   = vt[i].mtvec;
            mepc_in    = vt[i].mepc;
            if (vt[i].ttype == 2'b10) begin
                push(1'b0, 12'h300, vt[i].exp_mstatus, c + 1);
                push(1'b1, 12'h000, vt[i].exp_redir, c + 2);
            end else begin
                push_entry(c, vt[i].pc, vt[i].exp_mcause, vt[i].exp_mstatus, vt[i].exp_redir);
            end
            @(posedge clock); #1;
            trap_valid = 1'b0;
            wait_ready(busy);
            check($sformatf("busy_cycles_v%0d", i), busy, vt[i].busy);
        end

        // Reserved type held valid must never be taken
        trap_valid = 1'b1;
        trap_type  = 2'b11;
        trap_pc    = 32'h8000_0f00;
        for (int k = 0; k < 3; k++) begin
            @(posedge clock); #1;
            check("rsvd_ready", trap_ready, 1);
        end
        trap_valid = 1'b0;
        trap_type  = 2'b00;

        // Reset during WR_MCAUSE: only the mepc write survives
        @(posedge clock); #1;
        c          = cyc;
        redir_base = n_redir;
        trap_valid = 1'b1;
        trap_pc    = 32'h8000_0500;
        push(1'b0, 12'h341, 32'h8000_0500, c + 1);
        @(posedge clock); #1;
        trap_valid = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("abort_ready", trap_ready, 1);
        check("abort_own", csr_own, 0);
        repeat (4) @(posedge clock);
        #1;
        check("abort_no_redirect", n_redir - redir_base, 0);

        // Reset wins over a simultaneous request
        reset      = 1'b1;
        trap_valid = 1'b1;
        trap_type  = 2'b00;
        @(posedge clock); #1;
        reset      = 1'b0;
        trap_valid = 1'b0;
        check("reset_priority_ready", trap_ready, 1);

        // Back-to-back: second ecall held through the busy window
        @(posedge clock); #1;
        c          = cyc;
        redir_base = n_redir;
        csr_rdata  = 32'h0000_1808;
        mtvec_in   = 32'h8000_0700;
        trap_valid = 1'b1;
        trap_type  = 2'b00;
        trap_pc    = 32'h8000_0600;
        push_entry(c, 32'h8000_0600, 32'd11, 32'h0000_1880, 32'h8000_0700);
        @(posedge clock); #1;
        trap_pc = 32'h8000_0604;
        push_entry(c + 5, 32'h8000_0604, 32'd11, 32'h0000_1880, 32'h8000_0700);
        repeat (5) @(posedge clock);
        #1;
        trap_valid = 1'b0;
        check("b2b_second_taken", trap_ready, 0);
        wait_ready(busy);
        check("b2b_second_busy", busy, 4);
        check("b2b_redirects", n_redir - redir_base, 2);

        repeat (3) @(posedge clock);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        check("total_redirects", n_redir, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
